mul_seq_ctrl: RTL
=================

// Module: mul_seq_ctrl
// PURPOSE
//   Sequential shift-and-add multiplier with its own controller FSM.
//   Takes two unsigned WIDTH-bit operands on a Start strobe and iterates one partial
//   product per clock. Presents a registered 2*WIDTH-bit product with a Done/Ack handshake.
//   Sits beside the combinational iMul in the lab top level and is its small-area,
//   multi-cycle counterpart; the two are cross-checked operand for operand.
// PARAMETERS
//   WIDTH   4   operand width in bits (unsigned); product is 2*WIDTH bits
// PORTS
//   Clock      in   1          rising-edge clock
//   Reset_n    in   1          asynchronous active-low reset
//   Start      in   1          request a multiply; sampled only in IDLE
//   A          in   WIDTH      multiplicand; captured on the accepted Start edge
//   B          in   WIDTH      multiplier; captured on the accepted Start edge
//   Ack        in   1          consumer has taken ResultMul; sampled only in DONE
//   Busy       out  1          1 in RUN and DONE, 0 in IDLE
//   Done       out  1          1 exactly while in DONE (ResultMul valid)
//   ResultMul  out  2*WIDTH    registered product of last completed operation
// BEHAVIOUR
//   Reset (Reset_n=0, async)
//     - state=IDLE; Busy=0, Done=0, ResultMul=0; all internal regs 0.
//   Internal registers
//     - mcand (2*WIDTH, A zero-extended), mplier (WIDTH), acc (2*WIDTH),
//     - cnt (clog2(WIDTH+1) bits).
//   FSM states: IDLE, RUN, DONE (registered outputs decoded from state).
//   IDLE
//     - Start=1: mcand<={0,A}, mplier<=B, acc<=0, cnt<=0; go RUN.
//     - Start=0: stay. ResultMul holds its previous value.
//   RUN (one partial product per clock)
//     - if mplier[0]: acc<=acc+mcand (2*WIDTH-bit add, cannot overflow).
//     - mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
//     - When cnt==WIDTH-1, the final iteration executes this cycle:
//       - ResultMul <= acc+(mplier[0]?mcand:0); go DONE.
//     - Start is ignored in RUN; A/B may change freely without effect.
//   DONE
//     - Done=1, ResultMul stable.
//     - Ack=1: go IDLE. Start in the same cycle is ignored and must be
//       re-asserted in IDLE. Ack=0: stay; Done is held indefinitely.
//   Latency
//     - Start sampled at edge k -> Done=1 after edge k+WIDTH (WIDTH RUN cycles).
//     - Back-to-back minimum period = WIDTH+2 cycles (RUN x WIDTH, DONE, IDLE).
//   Boundaries
//     - A=0 or B=0 -> product 0, same latency (no early exit).
//     - Max operands -> (2^WIDTH-1)^2 fits in 2*WIDTH bits.
//     - Ack outside DONE is ignored.
//   Reset mid-operation
//     - Immediate return to IDLE with ResultMul=0; no stale Done after release.
// TESTING
//   1 reset, A=13 B=11 Start 1 cycle -> Done after 4 edges, ResultMul=8'h8F (143), Busy=1 throughout.
//   2 A=15 B=15 -> ResultMul=8'hE1 (225); A=0 B=9 -> 8'h00 with identical latency.
//   3 Start held high and A/B changed during RUN -> result of captured operands only; one DONE.
//   4 In DONE, Ack=0 for 5 cycles -> Done/ResultMul held; Ack=1 with Start=1 -> IDLE, no new op.
//   5 Reset_n low asynchronously in RUN cnt=2 -> Busy=Done=0, ResultMul=0 before next edge.
//   6 Exhaustive 256 pairs vs iMul/golden A*B, back-to-back at WIDTH+2 cycle period -> all match.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl - sequential shift-and-add unsigned multiplier with controller FSM.
//
// The operands are captured on an accepted Start. One partial product is added
// per clock for WIDTH clocks. The product is then presented on ResultMul with a
// Done/Ack handshake.
//
// Ports
//   Clock      in   1        rising-edge clock
//   Reset_n    in   1        asynchronous active-low reset
//   Start      in   1        request a multiply (sampled only in IDLE)
//   A          in   WIDTH    multiplicand, captured on the accepted Start edge
//   B          in   WIDTH    multiplier, captured on the accepted Start edge
//   Ack        in   1        consumer has taken ResultMul (sampled only in DONE)
//   Busy       out  1        high in RUN and DONE
//   Done       out  1        high exactly while in DONE
//   ResultMul  out  2*WIDTH  product of the last completed operation
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for Start; ResultMul holds the previous product
// RUN   | one partial product per clock, WIDTH clocks in total
// DONE  | product valid on ResultMul; waiting for Ack

module mul_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic                 Start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 Ack,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   ResultMul
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_result;

  logic [2*WIDTH-1:0]   w_addend;
  logic [2*WIDTH-1:0]   w_acc_next;

  // The running sum can never exceed (2^WIDTH-1)^2, so the add cannot overflow.
  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next = r_acc + w_addend;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_mcand  <= {{WIDTH{1'b0}}, A};
            r_mplier <= B;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end

        S_RUN: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          // The last partial product is folded straight into the result.
          if (r_cnt == LAST_CNT) begin
            r_result <= w_acc_next;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end

        S_DONE: begin
          // A Start arriving with Ack is dropped; it must be re-asserted in IDLE.
          if (Ack) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Busy      = r_busy;
  assign Done      = r_done;
  assign ResultMul = r_result;

endmodule
